// File: rtl/cache_fetch.sv
// ============================================================================
// Module   : cache_fetch
// Brief    : Direct-mapped read-only fetch cache with line refill from a
//            one-cycle-latency backing memory. Optional hit/miss counters
//            are enabled with the CACHE_FETCH_STATS_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fetch #(
    parameter int ANCHO = 32,
    parameter int PROF  = 8,
    parameter int IDX_W = 2,
    parameter int OFF_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [PROF-1:0]  addr_i,
    input  logic             flush_i,
    output logic             rdy_o,
    output logic [ANCHO-1:0] data_o,
    output logic             mem_rden_o,
    output logic [PROF-1:0]  mem_rdaddr_o,
    input  logic [ANCHO-1:0] mem_rddata_i
`ifdef CACHE_FETCH_STATS_EN
    ,
    output logic [15:0]      hits_o,
    output logic [15:0]      misses_o
`endif
);

    localparam int c_TAG_W = PROF - IDX_W - OFF_W;
    localparam int c_LINES = 2 ** IDX_W;
    localparam int c_WORDS = 2 ** OFF_W;
    localparam logic [OFF_W:0] c_CNT_LAST      = (OFF_W+1)'(c_WORDS);
    localparam logic [OFF_W:0] c_CNT_ISSUE_END = (OFF_W+1)'(c_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_REFILL = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    logic [PROF-1:0]     r_addr;
    logic [OFF_W:0]      r_cnt;
    logic [c_LINES-1:0]  r_valid;
    logic                r_rdy;
    logic [ANCHO-1:0]    r_data;
    logic                r_rden;
    logic [PROF-1:0]     r_rdaddr;

    logic [c_TAG_W-1:0]  r_tag_arr  [c_LINES];
    logic [ANCHO-1:0]    r_data_arr [c_LINES*c_WORDS];

    logic [OFF_W-1:0]    w_in_off;
    logic [IDX_W-1:0]    w_in_idx;
    logic [c_TAG_W-1:0]  w_in_tag;
    logic [OFF_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic                w_in_hit;
    logic [ANCHO-1:0]    w_in_word;
    logic [OFF_W-1:0]    w_wr_off;
    logic                w_data_we;
    logic                w_tag_we;
    logic [ANCHO-1:0]    w_resp_word;

    assign w_in_off = addr_i[OFF_W-1:0];
    assign w_in_idx = addr_i[OFF_W+IDX_W-1:OFF_W];
    assign w_in_tag = addr_i[PROF-1:OFF_W+IDX_W];
    assign w_off    = r_addr[OFF_W-1:0];
    assign w_idx    = r_addr[OFF_W+IDX_W-1:OFF_W];
    assign w_tag    = r_addr[PROF-1:OFF_W+IDX_W];

    // Lookup is evaluated on the incoming address so the hit response is
    // already registered when the FSM sits in LOOKUP.
    assign w_in_hit  = r_valid[w_in_idx] && (r_tag_arr[w_in_idx] == w_in_tag);
    assign w_in_word = r_data_arr[{w_in_idx, w_in_off}];

    // Refill data lags the issued address by one cycle, so word k-1 lands in cycle k.
    assign w_wr_off  = r_cnt[OFF_W-1:0] - OFF_W'(1);
    assign w_data_we = (r_state == S_REFILL) && (r_cnt != '0);
    assign w_tag_we  = (r_state == S_REFILL) && (r_cnt == c_CNT_LAST);

    // The requested word may be the one arriving in the final refill cycle.
    assign w_resp_word = (w_off == w_wr_off) ? mem_rddata_i : r_data_arr[{w_idx, w_off}];

    always_ff @(posedge clk_i) begin
        if (w_data_we) begin
            r_data_arr[{w_idx, w_wr_off}] <= mem_rddata_i;
        end
        if (w_tag_we) begin
            r_tag_arr[w_idx] <= w_tag;
        end
    end

`ifdef CACHE_FETCH_STATS_EN
    logic [15:0] r_hits;
    logic [15:0] r_misses;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_valid  <= '0;
            r_rdy    <= 1'b0;
            r_data   <= '0;
            r_rden   <= 1'b0;
            r_rdaddr <= '0;
`ifdef CACHE_FETCH_STATS_EN
            r_hits   <= '0;
            r_misses <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        r_valid <= '0;
                    end else if (req_i) begin
                        r_addr  <= addr_i;
                        r_state <= S_LOOKUP;
                        r_rdy   <= w_in_hit;
                        r_data  <= w_in_hit ? w_in_word : '0;
                    end
                end
                S_LOOKUP: begin
                    r_rdy  <= 1'b0;
                    r_data <= '0;
                    if (r_rdy) begin
                        r_state <= S_IDLE;
`ifdef CACHE_FETCH_STATS_EN
                        if (r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
`endif
                    end else begin
                        r_state  <= S_REFILL;
                        r_cnt    <= '0;
                        r_rden   <= 1'b1;
                        r_rdaddr <= {r_addr[PROF-1:OFF_W], OFF_W'(0)};
`ifdef CACHE_FETCH_STATS_EN
                        if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
`endif
                    end
                end
                S_REFILL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt < c_CNT_ISSUE_END) begin
                        r_rdaddr <= r_rdaddr + PROF'(1);
                    end else if (r_cnt == c_CNT_ISSUE_END) begin
                        r_rden   <= 1'b0;
                        r_rdaddr <= '0;
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        r_valid[w_idx] <= 1'b1;
                        r_state        <= S_RESP;
                        r_rdy          <= 1'b1;
                        r_data         <= w_resp_word;
                    end
                end
                S_RESP: begin
                    r_rdy   <= 1'b0;
                    r_data  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdy_o        = r_rdy;
    assign data_o       = r_data;
    assign mem_rden_o   = r_rden;
    assign mem_rdaddr_o = r_rdaddr;

`ifdef CACHE_FETCH_STATS_EN
    assign hits_o   = r_hits;
    assign misses_o = r_misses;
`endif

endmodule

`default_nettype wire
